// File: rtl/wb_slave_test_rams_pkg.sv
// Shared constants and types for the Wishbone test-RAM slave (mem1k / mem2k).
package wb_slave_test_rams_pkg;
  localparam int DATA_W    = 32;
  localparam int SEL_W     = DATA_W / 8;
  localparam int WB_ADDR_W = 11;
  localparam int MEM1K_AW  = 8;
  localparam int MEM2K_AW  = 9;

  localparam logic [31:0] BASE_RAMS_MEM1K = 32'h0000_1000;
  localparam logic [31:0] BASE_RAMS_MEM2K = 32'h0000_0000;
  localparam int SIZE_RAMS_MEM1K = 256;
  localparam int SIZE_RAMS_MEM2K = 512;

  // Word-address bit that splits the two regions (byte base 0x1000 -> word bit 10).
  localparam int MEM1K_SEL_BIT = $clog2(BASE_RAMS_MEM1K) - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_ACK
  } bus_state_e;
endpackage

// File: rtl/wb_slave_test_rams_if.sv
// Wishbone classic bus bundle for the test-RAM slave.
interface wb_slave_test_rams_if;
  import wb_slave_test_rams_pkg::*;

  logic [WB_ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0]    wb_data_i;
  logic [DATA_W-1:0]    wb_data_o;
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_we_i;
  logic [SEL_W-1:0]     wb_sel_i;
  logic                 wb_ack_o;

  modport slave (
    input  wb_addr_i, wb_data_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    output wb_data_o, wb_ack_o
  );

  modport master (
    output wb_addr_i, wb_data_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    input  wb_data_o, wb_ack_o
  );
endinterface

// File: rtl/wb_slave_test_rams_dpram.sv
// test_rams_dpram: two-port 32-bit RAM, per-port byte enables, read-first,
// registered read data that holds between reads. Port B writes land after port A.
module test_rams_dpram
  import wb_slave_test_rams_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     a_addr_i,
  input  logic              a_rd_i,
  input  logic              a_wr_i,
  input  logic [SEL_W-1:0]  a_be_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [AW-1:0]     b_addr_i,
  input  logic              b_rd_i,
  input  logic              b_wr_i,
  input  logic [SEL_W-1:0]  b_be_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o
);
  logic [SEL_W-1:0][7:0] mem [DEPTH];
  logic [DATA_W-1:0]     a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]     b_rdata_q, b_rdata_d;

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_rd_i) a_rdata_d = mem[a_addr_i];
    if (b_rd_i) b_rdata_d = mem[b_addr_i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Contents survive reset; on a same-word collision port B's bytes win.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (a_wr_i && a_be_i[i]) mem[a_addr_i][i] <= a_wdata_i[8*i +: 8];
      if (b_wr_i && b_be_i[i]) mem[b_addr_i][i] <= b_wdata_i[8*i +: 8];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;
endmodule

// File: rtl/wb_slave_test_rams.sv
// Wishbone slave exposing mem1k (256x32, user R/W) and mem2k (512x32, user RO).
// mem2k storage exists only when WB_TEST_RAMS_MEM2K_EN is defined.
module wb_slave_test_rams
  import wb_slave_test_rams_pkg::*;
(
  input  logic                 wb_clk_i,
  input  logic                 rst_i,
  wb_slave_test_rams_if.slave  wb,
  input  logic [MEM1K_AW-1:0]  rams_mem1k_addr_i,
  input  logic [DATA_W-1:0]    rams_mem1k_data_i,
  output logic [DATA_W-1:0]    rams_mem1k_data_o,
  input  logic                 rams_mem1k_rd_i,
  input  logic                 rams_mem1k_wr_i,
  input  logic [SEL_W-1:0]     rams_mem1k_bwsel_i,
  input  logic [MEM2K_AW-1:0]  rams_mem2k_addr_i,
  input  logic                 rams_mem2k_rd_i,
  output logic [DATA_W-1:0]    rams_mem2k_data_o
);
  bus_state_e        state_q, state_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              m1_sel_q, m1_sel_d;
  logic              start, addr_m1;
  logic [DATA_W-1:0] m1_rdata, m2_rdata;

  assign start   = (state_q == ST_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
  assign addr_m1 = wb.wb_addr_i[MEM1K_SEL_BIT];

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    data_d   = '0;
    m1_sel_d = m1_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m1_sel_d = addr_m1;
          if (wb.wb_we_i) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      // Dropping cyc here abandons the read without an ack.
      ST_RD_WAIT: begin
        if (wb.wb_cyc_i) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          data_d  = m1_sel_q ? m1_rdata : m2_rdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      data_q   <= '0;
      m1_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      m1_sel_q <= m1_sel_d;
    end
  end

  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_data_o = data_q;

  test_rams_dpram #(.DEPTH(SIZE_RAMS_MEM1K)) u_mem1k (
    .clk       (wb_clk_i),
    .rst       (rst_i),
    .a_addr_i  (wb.wb_addr_i[MEM1K_AW-1:0]),
    .a_rd_i    (start && !wb.wb_we_i && addr_m1),
    .a_wr_i    (start && wb.wb_we_i && addr_m1),
    .a_be_i    (wb.wb_sel_i),
    .a_wdata_i (wb.wb_data_i),
    .a_rdata_o (m1_rdata),
    .b_addr_i  (rams_mem1k_addr_i),
    .b_rd_i    (rams_mem1k_rd_i),
    .b_wr_i    (rams_mem1k_wr_i),
    .b_be_i    (rams_mem1k_bwsel_i),
    .b_wdata_i (rams_mem1k_data_i),
    .b_rdata_o (rams_mem1k_data_o)
  );

  logic unused_addr;
  assign unused_addr = wb.wb_addr_i[9];

`ifdef WB_TEST_RAMS_MEM2K_EN
  test_rams_dpram #(.DEPTH(SIZE_RAMS_MEM2K)) u_mem2k (
    .clk       (wb_clk_i),
    .rst       (rst_i),
    .a_addr_i  (wb.wb_addr_i[MEM2K_AW-1:0]),
    .a_rd_i    (start && !wb.wb_we_i && !addr_m1),
    .a_wr_i    (start && wb.wb_we_i && !addr_m1),
    .a_be_i    (wb.wb_sel_i),
    .a_wdata_i (wb.wb_data_i),
    .a_rdata_o (m2_rdata),
    .b_addr_i  (rams_mem2k_addr_i),
    .b_rd_i    (rams_mem2k_rd_i),
    .b_wr_i    (1'b0),
    .b_be_i    ('0),
    .b_wdata_i ('0),
    .b_rdata_o (rams_mem2k_data_o)
  );
`else
  // Region still acks normally; writes vanish and reads return zero.
  assign m2_rdata          = '0;
  assign rams_mem2k_data_o = '0;
  logic unused_mem2k;
  assign unused_mem2k = ^{rams_mem2k_addr_i, rams_mem2k_rd_i, wb.wb_addr_i[8]};
`endif
endmodule

// File: tb/tb_wb_slave_test_rams.sv
// Scoreboard bench for wb_slave_test_rams: directed cases plus random traffic
// against an array model of both RAMs.
module tb_wb_slave_test_rams;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_slave_test_rams_if wb_bus ();
  logic [7:0]  u1_addr;
  logic [31:0] u1_wdata, u1_rdata;
  logic        u1_rd, u1_wr;
  logic [3:0]  u1_be;
  logic [8:0]  u2_addr;
  logic        u2_rd;
  logic [31:0] u2_rdata;

  wb_slave_test_rams dut (
    .wb_clk_i           (clk),
    .rst_i              (rst),
    .wb                 (wb_bus),
    .rams_mem1k_addr_i  (u1_addr),
    .rams_mem1k_data_i  (u1_wdata),
    .rams_mem1k_data_o  (u1_rdata),
    .rams_mem1k_rd_i    (u1_rd),
    .rams_mem1k_wr_i    (u1_wr),
    .rams_mem1k_bwsel_i (u1_be),
    .rams_mem2k_addr_i  (u2_addr),
    .rams_mem2k_rd_i    (u2_rd),
    .rams_mem2k_data_o  (u2_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  logic [31:0] m1 [256];
  logic [31:0] m2 [512];
  exp_t        bq[$];
  logic [31:0] u1q[$], u2q[$];
  logic [31:0] u1_exp = '0, u2_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Word address >= 1024 is the mem1k window (mirrored), below it mem2k.
  function automatic logic [31:0] model_rd(input int word);
    if (word >= 1024) return m1[word % 256];
`ifdef WB_TEST_RAMS_MEM2K_EN
    return m2[word % 512];
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_wr(input int word, input logic [31:0] d, input logic [3:0] sel);
    if (word >= 1024) m1[word % 256] = merge(m1[word % 256], d, sel);
    else m2[word % 512] = merge(m2[word % 512], d, sel);
  endtask

  // Expected user-port data advances on every sampled rd strobe; reset clears it.
  always @(posedge clk) begin
    if (rst) begin
      u1_exp <= '0;
      u2_exp <= '0;
    end else begin
      if (u1_rd && u1q.size() > 0) u1_exp <= u1q.pop_front();
      if (u2_rd && u2q.size() > 0) u2_exp <= u2q.pop_front();
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    check("mem1k_user_data", u1_rdata, u1_exp);
    check("mem2k_user_data", u2_rdata, u2_exp);
    if (!wb_bus.wb_ack_o) begin
      check("wb_data_without_ack", wb_bus.wb_data_o, 32'h0);
    end else if (bq.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_ack: got ack=1 expected ack=0 at %0t", $time);
    end else begin
      mon_e = bq.pop_front();
      if (mon_e.is_rd) check("wb_read_data", wb_bus.wb_data_o, mon_e.data);
    end
  end

  task automatic bus_acc(input bit we, input int word, input logic [31:0] d,
                         input logic [3:0] sel, input bit with_user,
                         input logic [31:0] ud, input logic [3:0] ube);
    exp_t e;
    int   lat;
    @(negedge clk);
    wb_bus.wb_addr_i = word[10:0];
    wb_bus.wb_data_i = d;
    wb_bus.wb_sel_i  = sel;
    wb_bus.wb_we_i   = we;
    wb_bus.wb_cyc_i  = 1'b1;
    wb_bus.wb_stb_i  = 1'b1;
    if (with_user) begin
      u1_addr  = word[7:0];
      u1_wdata = ud;
      u1_be    = ube;
      u1_wr    = 1'b1;
    end
    e.is_rd = !we;
    e.data  = we ? 32'h0 : model_rd(word);
    if (we) model_wr(word, d, sel);
    if (with_user) m1[word % 256] = merge(m1[word % 256], ud, ube);
    bq.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      u1_wr = 1'b0;
    end while (!wb_bus.wb_ack_o && lat < 8);
    check(we ? "wr_ack_latency" : "rd_ack_latency", lat, we ? 32'd1 : 32'd2);
    wb_bus.wb_cyc_i = 1'b0;
    wb_bus.wb_stb_i = 1'b0;
    wb_bus.wb_we_i  = 1'b0;
  endtask

  task automatic bus_wr(input int word, input logic [31:0] d, input logic [3:0] sel);
    bus_acc(1'b1, word, d, sel, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic bus_rd(input int word);
    bus_acc(1'b0, word, 32'h0, 4'hf, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic u1_op(input bit rd, input bit wr, input int idx, input logic [31:0] d,
                       input logic [3:0] be);
    @(negedge clk);
    u1_addr  = idx[7:0];
    u1_wdata = d;
    u1_be    = be;
    u1_rd    = rd;
    u1_wr    = wr;
    if (rd) u1q.push_back(m1[idx]);
    if (wr) m1[idx] = merge(m1[idx], d, be);
    @(negedge clk);
    u1_rd = 1'b0;
    u1_wr = 1'b0;
  endtask

  task automatic u2_read(input int idx);
    @(negedge clk);
    u2_addr = idx[8:0];
    u2_rd   = 1'b1;
    u2q.push_back(model_rd(idx));
    @(negedge clk);
    u2_rd = 1'b0;
  endtask

  // Starts a read, then either drops cyc or pulses reset in its wait cycle.
  task automatic read_abort(input int word, input bit use_reset);
    @(negedge clk);
    wb_bus.wb_addr_i = word[10:0];
    wb_bus.wb_we_i   = 1'b0;
    wb_bus.wb_cyc_i  = 1'b1;
    wb_bus.wb_stb_i  = 1'b1;
    @(negedge clk);
    wb_bus.wb_cyc_i = 1'b0;
    wb_bus.wb_stb_i = 1'b0;
    if (use_reset) rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      check("abort_no_ack", {31'h0, wb_bus.wb_ack_o}, 32'h0);
      check("abort_data_zero", wb_bus.wb_data_o, 32'h0);
      @(negedge clk);
    end
  endtask

  initial begin
    int w, op;
    wb_bus.wb_addr_i = '0;
    wb_bus.wb_data_i = '0;
    wb_bus.wb_sel_i  = '0;
    wb_bus.wb_we_i   = 1'b0;
    wb_bus.wb_cyc_i  = 1'b0;
    wb_bus.wb_stb_i  = 1'b0;
    u1_addr = '0; u1_wdata = '0; u1_rd = 1'b0; u1_wr = 1'b0; u1_be = '0;
    u2_addr = '0; u2_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ack", {31'h0, wb_bus.wb_ack_o}, 32'h0);
    check("reset_wb_data", wb_bus.wb_data_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) u1_op(1'b0, 1'b1, i, 257 - i, 4'hf);
    bus_rd(1024);
    bus_rd(1025);
    check("user_fill_word0", m1[0], 32'd257);

    for (int i = 0; i < 512; i++) bus_wr(i, 113 * i + 41, 4'hf);
    for (int i = 0; i < 512; i++) u2_read(i);

    bus_wr(32'h1000 >> 2, 32'hdeadbeef, 4'hf);
    bus_wr(32'h1004 >> 2, 32'hcafecafe, 4'hf);
    bus_wr(32'h1200 >> 2, 32'hfacedead, 4'hf);
    bus_rd(32'h1000 >> 2);
    bus_rd(32'h1004 >> 2);
    bus_rd(32'h1200 >> 2);

    bus_wr(32'h1010 >> 2, 32'h55555555, 4'hf);
    bus_rd(32'h1010 >> 2);
    bus_wr((32'h1000 + 4 * 256 + 16) >> 2, 32'haaaaaaaa, 4'hf);
    bus_rd(32'h1010 >> 2);

    bus_wr(32'h1040 >> 2, 32'h11223344, 4'hf);
    bus_wr(32'h1040 >> 2, 32'h000000ff, 4'h1);
    bus_rd(32'h1040 >> 2);
    bus_acc(1'b1, 32'h1040 >> 2, 32'haaaaaaaa, 4'hf, 1'b1, 32'h55555555, 4'h3);
    bus_rd(32'h1040 >> 2);
    bus_acc(1'b0, 32'h1040 >> 2, 32'h0, 4'hf, 1'b1, 32'h12345678, 4'hf);
    u1_op(1'b1, 1'b1, 16, 32'h0badf00d, 4'hf);
    u1_op(1'b1, 1'b0, 16, 32'h0, 4'h0);

    u1_op(1'b1, 1'b0, 5, 32'h0, 4'h0);
    read_abort(32'h1000 >> 2, 1'b0);
    read_abort(32'h1000 >> 2, 1'b1);
    bus_rd(32'h1000 >> 2);
    bus_rd(32'h1004 >> 2);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 6);
      w  = $urandom_range(0, 2047);
      case (op)
        0: bus_wr(w, $urandom, 4'($urandom_range(0, 15)));
        1: bus_rd(w);
        2: bus_acc(1'b1, 1024 + (w % 1024), $urandom, 4'($urandom_range(0, 15)),
                   1'b1, $urandom, 4'($urandom_range(0, 15)));
        3: bus_acc(1'b0, 1024 + (w % 1024), 32'h0, 4'hf, 1'b1, $urandom,
                   4'($urandom_range(0, 15)));
        4: u1_op(1'b0, 1'b1, w % 256, $urandom, 4'($urandom_range(0, 15)));
        5: u1_op(1'b1, 1'($urandom_range(0, 1)), w % 256, $urandom, 4'hf);
        default: u2_read(w % 512);
      endcase
    end

    repeat (3) @(negedge clk);
    check("bus_queue_drained", bq.size(), 32'h0);
    check("user_queue_drained", u1q.size() + u2q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
